// File: rtl/uart_rx_loader_pkg.sv
// uart_rx_loader_pkg -- shared SoC definitions: bus width, byte count, receiver state encoding.
// Revision 1.0 -- initial release.
`default_nettype none

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 32
`endif

package uart_rx_loader_pkg;

  localparam int DATA_W = `DATA_BUS_LEN;
  localparam int NBYTES = `DATA_BUS_LEN / 8;
  localparam int BYTE_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// sync2 -- two-flop synchronizer for a single asynchronous bit, with selectable reset value.
// Revision 1.0 -- initial release.
`default_nettype none

module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_loader.sv
// uart_rx_loader -- 8N1 UART receiver packing little-endian bytes into a bus word with a write strobe.
// Revision 1.0 -- initial release.
`default_nettype none

module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              WR_OUT,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);

  rx_state_t             state;
  logic                  rxs;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic [BYTE_IDX_W-1:0] byte_idx;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync2 (
    .CLK(CLK),
    .RST(RST),
    .d  (RXD),
    .q  (rxs)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_idx  <= '0;
      DATA_OUT  <= '0;
      WR_OUT    <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      WR_OUT    <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              // Glitch: fall back, still busy if a partial word is held.
              state <= ST_IDLE;
              BUSY  <= (byte_idx != '0);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (rxs) begin
              DATA_OUT[{byte_idx, 3'b000} +: 8] <= shreg;
              if (byte_idx == LAST_BYTE) begin
                byte_idx <= '0;
                WR_OUT   <= 1'b1;
                BUSY     <= 1'b0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                BUSY     <= 1'b1;
              end
            end else begin
              FRAME_ERR <= 1'b1;
              byte_idx  <= '0;
              BUSY      <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_loader.sv
// tb_uart_rx_loader -- directed and randomized frames checked against a byte-queue reference model.
// Revision 1.0 -- initial release.
`timescale 1ns/1ps
`default_nettype none

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 32
`endif

module tb_uart_rx_loader;

  localparam int CPB = 16;
  localparam int W   = `DATA_BUS_LEN;
  localparam int NB  = W / 8;
  // Start edge to WR_OUT: stop-bit mid sample point on RXD, plus 2 sync flops, plus 1 register stage.
  localparam int LAT = (CPB / 2 + 9 * CPB) + 2 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rxd = 1'b1;
  logic [W-1:0] data_out;
  logic         wr_out;
  logic         frame_err;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] got_words[$];
  int           got_cyc[$];
  int           got_fe  = 0;
  int           both_hi = 0;

  logic [7:0]   pending[$];
  logic [W-1:0] exp_words[$];
  int           exp_fe = 0;
  int           last_start = 0;
  int           wb = 0, eb = 0, fb = 0, efb = 0;

  uart_rx_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RXD      (rxd),
    .DATA_OUT (data_out),
    .WR_OUT   (wr_out),
    .FRAME_ERR(frame_err),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_out) begin
      got_words.push_back(data_out);
      got_cyc.push_back(cyc);
    end
    if (frame_err) got_fe <= got_fe + 1;
    if (wr_out && frame_err) both_hi <= both_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: accepted bytes queue up; every NB of them form one word, first byte lowest.
  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    logic [W-1:0] w;
    if (!stop_ok) begin
      exp_fe++;
      pending.delete();
      return;
    end
    pending.push_back(b);
    if (pending.size() == NB) begin
      w = '0;
      for (int i = 0; i < NB; i++) w = w | (W'(pending[i]) << (8 * i));
      exp_words.push_back(w);
      pending.delete();
    end
  endfunction

  task automatic do_reset(input int n);
    rxd = 1'b1;
    rst = 1'b1;
    step(n);
    rst = 1'b0;
    pending.delete();
  endtask

  // Bit i spans cycles [round(i*per10/10), round((i+1)*per10/10)) after the start edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int per10, input int abort_bits);
    logic [9:0] frame;
    int n;
    frame = {stop_ok, b, 1'b0};
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      if (abort_bits > 0 && i == abort_bits) begin
        do_reset(2);
        return;
      end
      rxd = frame[i];
      n = ((i + 1) * per10 + 5) / 10 - (i * per10 + 5) / 10;
      step(n);
    end
    rxd = 1'b1;
    model_byte(b, stop_ok);
  endtask

  task automatic phase_check(input string tag);
    step(40);
    check({tag, ":words"}, 64'(got_words.size() - wb), 64'(exp_words.size() - eb));
    for (int i = 0; i < exp_words.size() - eb && i < got_words.size() - wb; i++)
      check({tag, ":word"}, 64'(got_words[wb + i]), 64'(exp_words[eb + i]));
    check({tag, ":ferr"}, 64'(got_fe - fb), 64'(exp_fe - efb));
    check({tag, ":wr_and_fe"}, 64'(both_hi), 64'd0);
    wb  = got_words.size();
    eb  = exp_words.size();
    fb  = got_fe;
    efb = exp_fe;
  endtask

  initial begin
    logic [7:0] b;
    logic [31:0] v;
    int w0;
    bit ok;

    // Reset state
    step(3);
    check("rst:data_out", 64'(data_out), 64'd0);
    check("rst:wr_out", 64'(wr_out), 64'd0);
    check("rst:frame_err", 64'(frame_err), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step(5);

    // Basic word, with latency and partial-word busy
    w0 = got_words.size();
    v = 32'h12345678;
    for (int i = 0; i < NB; i++) begin
      send_frame(8'(v >> (8 * (i % 4))), 1'b1, 10 * CPB, 0);
      step(2);
      if (i == 1) check("basic:busy_partial", 64'(busy), 64'd1);
    end
    check("basic:latency", 64'((got_cyc.size() > w0) ? got_cyc[w0] - last_start : -1), 64'(LAT));
    check("basic:busy_done", 64'(busy), 64'd0);
    phase_check("basic");

    // Frame error followed by a good word
    send_frame(8'hAA, 1'b0, 10 * CPB, 0);
    step(48);
    for (int i = 0; i < NB; i++) send_frame(8'(i % 4 + 1), 1'b1, 10 * CPB, 0);
    phase_check("ferr");

    // Short low glitch on an idle line
    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    step(2);
    check("glitch:busy_start", 64'(busy), 64'd1);
    step(8);
    check("glitch:busy_idle", 64'(busy), 64'd0);
    phase_check("glitch");

    // Reset between bytes and mid-frame, then a fresh word
    for (int i = 0; i < 2; i++) send_frame(8'($urandom), 1'b1, 10 * CPB, 0);
    step(3);
    do_reset(2);
    check("rstmid:data_out", 64'(data_out), 64'd0);
    check("rstmid:busy", 64'(busy), 64'd0);
    send_frame(8'h5A, 1'b1, 10 * CPB, 5);
    step(30);
    v = 32'hDEADBEEF;
    for (int i = 0; i < NB; i++) send_frame(8'(v >> (8 * (i % 4))), 1'b1, 10 * CPB, 0);
    phase_check("rstmid");

    // Back-to-back frames, no idle gap
    for (int i = 0; i < 2 * NB; i++) send_frame(8'($urandom), 1'b1, 10 * CPB, 0);
    phase_check("b2b");

    // Bit period skewed +5% then -5%
    v = 32'h12345678;
    for (int i = 0; i < NB; i++) begin
      send_frame(8'(v >> (8 * (i % 4))), 1'b1, 168, 0);
      step(4);
    end
    phase_check("slow");
    for (int i = 0; i < NB; i++) begin
      send_frame(8'(v >> (8 * (i % 4))), 1'b1, 152, 0);
      step(4);
    end
    phase_check("fast");

    // Randomized traffic with occasional bad stop bits
    for (int i = 0; i < 60; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(7) != 0);
      send_frame(b, ok, 10 * CPB, 0);
      step(ok ? $urandom_range(20) : 40 + $urandom_range(20));
    end
    phase_check("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
